// File: rtl/pipe_stage_buf_if.sv
// Valid/ready channel carrying a payload and a control bundle
// between two elastic pipeline stages.
interface pipe_stage_buf_if #(
  parameter int DATA_W = 16,
  parameter int CTRL_W = 16
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [CTRL_W-1:0] ctrl;

  modport master (
    output valid,
    output data,
    output ctrl,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  ctrl,
    output ready
  );
endinterface

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline stage register with optional skid entry,
// bubble insertion, flush and a saturating stall counter.
module pipe_stage_buf #(
  parameter int DATA_W = 16,
  parameter int CTRL_W = 16,
  parameter bit SKID   = 1'b1,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  pipe_stage_buf_if.slave  up,
  pipe_stage_buf_if.master dn,
  input  logic             kill,
  input  logic             flush,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] stall_cnt
);
  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } state_t;

  state_t            state;
  logic              ready_r;
  logic              valid;
  logic              accept;
  logic              pop;
  logic [DATA_W-1:0] main_data;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [CTRL_W-1:0] in_ctrl;

  assign valid    = (state != EMPTY);
  assign accept   = up.valid & up.ready & ~flush;
  assign pop      = valid & dn.ready;
  assign in_ctrl  = kill ? '0 : up.ctrl;
  assign dn.valid = valid;
  assign dn.data  = main_data;
  assign dn.ctrl  = valid ? main_ctrl : '0;

  // Single-entry mode trades the registered ready for a comb path
  assign up.ready = SKID ? ready_r
                         : (~valid | dn.ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      ready_r   <= 1'b1;
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else if (flush) begin
      state     <= EMPTY;
      ready_r   <= 1'b1;
      main_ctrl <= '0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            main_data <= up.data;
            main_ctrl <= in_ctrl;
            state     <= ONE;
          end
        end
        ONE: begin
          if (accept && !pop) begin
            skid_data <= up.data;
            skid_ctrl <= in_ctrl;
            state     <= TWO;
            ready_r   <= 1'b0;
          end else if (accept) begin
            main_data <= up.data;
            main_ctrl <= in_ctrl;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            main_data <= skid_data;
            main_ctrl <= skid_ctrl;
            state     <= ONE;
            ready_r   <= 1'b1;
          end
        end
        default: begin
          state   <= EMPTY;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (clr_cnt) begin
      stall_cnt <= '0;
    end else if (valid && !dn.ready && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: skid and single-entry instances share
// stimulus and are compared against a FIFO reference model.
module tb_pipe_stage_buf;
  localparam int DW  = 16;
  localparam int CW  = 16;
  localparam int NW  = 4;
  localparam int MAX = (1 << NW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          out_ready;
  logic          kill;
  logic          flush;
  logic          clr_cnt;
  logic [NW-1:0] cnt_a;
  logic [NW-1:0] cnt_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_stage_buf_if #(.DATA_W(DW), .CTRL_W(CW)) up_a ();
  pipe_stage_buf_if #(.DATA_W(DW), .CTRL_W(CW)) dn_a ();
  pipe_stage_buf_if #(.DATA_W(DW), .CTRL_W(CW)) up_b ();
  pipe_stage_buf_if #(.DATA_W(DW), .CTRL_W(CW)) dn_b ();

  assign up_a.valid = in_valid;
  assign up_a.data  = in_data;
  assign up_a.ctrl  = in_ctrl;
  assign dn_a.ready = out_ready;
  assign up_b.valid = in_valid;
  assign up_b.data  = in_data;
  assign up_b.ctrl  = in_ctrl;
  assign dn_b.ready = out_ready;

  pipe_stage_buf #(
    .DATA_W(DW), .CTRL_W(CW), .SKID(1'b1), .CNT_W(NW)
  ) u_skid (
    .clk(clk), .rst(rst),
    .up(up_a.slave), .dn(dn_a.master),
    .kill(kill), .flush(flush), .clr_cnt(clr_cnt),
    .stall_cnt(cnt_a)
  );

  pipe_stage_buf #(
    .DATA_W(DW), .CTRL_W(CW), .SKID(1'b0), .CNT_W(NW)
  ) u_single (
    .clk(clk), .rst(rst),
    .up(up_b.slave), .dn(dn_b.master),
    .kill(kill), .flush(flush), .clr_cnt(clr_cnt),
    .stall_cnt(cnt_b)
  );

  // Model: k=1 is the skid instance (depth 2), k=0 single (depth 1)
  logic [DW+CW-1:0] q    [2][2];
  int               n    [2];
  logic [DW-1:0]    last [2];
  int               cnt  [2];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic m_ready(input int k);
    if (k == 1) return n[k] < 2;
    return (n[k] == 0) || out_ready;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      n[k]    = 0;
      last[k] = '0;
      cnt[k]  = 0;
    end
  endtask

  task automatic check_all();
    logic [CW-1:0] ec;
    for (int k = 0; k < 2; k++) begin
      ec = (n[k] > 0) ? q[k][0][CW-1:0] : '0;
      if (k == 1) begin
        check("a.valid", 32'(dn_a.valid), 32'(n[k] > 0));
        check("a.data", 32'(dn_a.data), 32'(last[k]));
        check("a.ctrl", 32'(dn_a.ctrl), 32'(ec));
        check("a.ready", 32'(up_a.ready), 32'(m_ready(k)));
        check("a.cnt", 32'(cnt_a), 32'(cnt[k]));
      end else begin
        check("b.valid", 32'(dn_b.valid), 32'(n[k] > 0));
        check("b.data", 32'(dn_b.data), 32'(last[k]));
        check("b.ctrl", 32'(dn_b.ctrl), 32'(ec));
        check("b.ready", 32'(up_b.ready), 32'(m_ready(k)));
        check("b.cnt", 32'(cnt_b), 32'(cnt[k]));
      end
    end
  endtask

  // Called at the negedge: drive, check, advance one clock
  task automatic step(input logic          v,
                      input logic [DW-1:0] d,
                      input logic [CW-1:0] c,
                      input logic          r,
                      input logic          kl,
                      input logic          fl,
                      input logic          cl);
    logic acc [2];
    logic pp  [2];
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = r;
    kill      = kl;
    flush     = fl;
    clr_cnt   = cl;
    #1;
    check_all();
    for (int k = 0; k < 2; k++) begin
      acc[k] = v && m_ready(k) && !fl;
      pp[k]  = (n[k] > 0) && r;
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (cl) cnt[k] = 0;
      else if (n[k] > 0 && !r && cnt[k] < MAX) cnt[k]++;
      if (fl) begin
        n[k] = 0;
      end else begin
        if (pp[k]) begin
          q[k][0] = q[k][1];
          n[k]--;
        end
        if (acc[k]) begin
          q[k][n[k]] = {d, kl ? {CW{1'b0}} : c};
          n[k]++;
        end
      end
      if (n[k] > 0) last[k] = q[k][0][DW+CW-1:CW];
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic r);
    step(1'b0, '0, '0, r, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_ctrl   = '0;
    out_ready = 1'b0;
    kill      = 1'b0;
    flush     = 1'b0;
    clr_cnt   = 1'b0;
    m_reset();
    @(negedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // Back-pressure then drain
    step(1'b1, 16'h0001, 16'h0011, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0002, 16'h0022, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // Full throughput
    for (int i = 0; i < 8; i++)
      step(1'b1, 16'(i), 16'(i + 8), 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Kill makes a bubble that keeps its payload
    step(1'b1, 16'h1234, 16'h00FF, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Flush from two held entries with a live input
    step(1'b1, 16'hAAAA, 16'h0101, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'hBBBB, 16'h0202, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'hCCCC, 16'h0303, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Stall counter saturation and clear
    step(1'b1, 16'h0055, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) idle(1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);

    // Asynchronous reset between edges while holding entries
    step(1'b1, 16'h0F0F, 16'h0A0A, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'hF0F0, 16'h0B0B, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("rst.a.valid", 32'(dn_a.valid), 32'd0);
    check("rst.a.ctrl", 32'(dn_a.ctrl), 32'd0);
    check("rst.a.cnt", 32'(cnt_a), 32'd0);
    check("rst.a.ready", 32'(up_a.ready), 32'd1);
    check("rst.b.valid", 32'(dn_b.valid), 32'd0);
    check("rst.b.cnt", 32'(cnt_b), 32'd0);
    m_reset();
    @(negedge clk);
    rst = 1'b0;

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0,
           16'($urandom),
           16'($urandom),
           $urandom_range(0, 2) != 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 15) == 0,
           $urandom_range(0, 31) == 0);
    end
    idle(1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
